mem_access_controller: RTL and testbench

- CPU-side initiator for the data-path RAM: the other end of the enable / read_write / data_length / address / data_in / data_out / mfc interface.
- Accepts one load/store request from the control unit and checks alignment.
- Drives the RAM with a four-phase enable/mfc handshake, extends read data to 32 bits, and reports done or fault.
- Sits between the control unit and the data-path RAM.

---
 rtl/mem_if_pkg.sv | 36 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/mem_access_controller.sv | 148 ++++++++++++++
 tb/tb_mem_access_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared encodings for the CPU-side RAM access controller:
// transfer sizes, fault codes, FSM states and the read-data extender.
package mem_if_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FLT_SIZE     = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MFC,
    RELEASE,
    DONE,
    FAULT
  } state_t;

  // Right-justified RAM data widened to 32 bits according to size/signedness.
  function automatic logic [31:0] extend_rdata(input logic [31:0] d,
                                               input logic [1:0]  size,
                                               input logic        sgn);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {{24{sgn & d[7]}}, d[7:0]};
      SZ_HALF: r = {{16{sgn & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with asynchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/mem_access_controller.sv
// CPU-side initiator for the data-path RAM: accepts one load/store, checks
// alignment, runs the enable/mfc four-phase handshake and reports done/fault.
module mem_access_controller
  import mem_if_pkg::*;
#(
  parameter int ADDR_W         = 9,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [31:0]       rdata,
  output logic              mem_enable,
  output logic              mem_read_write,
  output logic [1:0]        mem_data_length,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out,
  input  logic              mem_mfc
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t            state_reg, state_next;
  logic              rw_reg, signed_reg, mem_enable_reg, tmo_flag_reg;
  logic [1:0]        size_reg, fault_code_reg, accept_code;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg, rdata_reg;
  logic [7:0]        tmo_cnt_reg, tmo_cnt_inc;
  logic              mfc_s, accept, mfc_hit, tmo_hit, release_exit;

  sync_2ff u_mfc_sync (
    .clk (clk),
    .rst (reset),
    .d   (mem_mfc),
    .q   (mfc_s)
  );

  assign tmo_cnt_inc = (tmo_cnt_reg == 8'hFF) ? 8'hFF : tmo_cnt_reg + 8'd1;

  always_comb begin
    if (req_size == SZ_ILLEGAL)
      accept_code = FLT_SIZE;
    else if ((req_size == SZ_HALF && req_addr[0]) ||
             (req_size == SZ_WORD && req_addr[1:0] != 2'b00))
      accept_code = FLT_MISALIGN;
    else
      accept_code = FLT_NONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    accept       = 1'b0;
    mfc_hit      = 1'b0;
    tmo_hit      = 1'b0;
    release_exit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          accept     = 1'b1;
          state_next = (accept_code == FLT_NONE) ? WAIT_MFC : FAULT;
        end
      end
      WAIT_MFC: begin
        // A completing handshake wins over a coincident timeout.
        if (mfc_s) begin
          mfc_hit    = 1'b1;
          state_next = RELEASE;
        end else if (tmo_cnt_inc >= TMO_LIMIT) begin
          tmo_hit    = 1'b1;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!mfc_s) begin
          release_exit = 1'b1;
          state_next   = tmo_flag_reg ? FAULT : DONE;
        end
      end
      DONE:    state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_reg         <= 1'b0;
      size_reg       <= 2'b00;
      signed_reg     <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= 32'd0;
      mem_enable_reg <= 1'b0;
      tmo_cnt_reg    <= 8'd0;
      tmo_flag_reg   <= 1'b0;
      fault_code_reg <= FLT_NONE;
      rdata_reg      <= 32'd0;
    end else begin
      if (accept) begin
        rw_reg         <= req_rw;
        size_reg       <= req_size;
        signed_reg     <= req_signed;
        addr_reg       <= req_addr;
        wdata_reg      <= req_wdata;
        fault_code_reg <= accept_code;
        mem_enable_reg <= (accept_code == FLT_NONE);
        tmo_cnt_reg    <= 8'd0;
        tmo_flag_reg   <= 1'b0;
      end
      if (state_reg == WAIT_MFC) tmo_cnt_reg <= tmo_cnt_inc;
      if (mfc_hit) begin
        mem_enable_reg <= 1'b0;
        if (rw_reg) rdata_reg <= extend_rdata(mem_data_out, size_reg, signed_reg);
      end
      if (tmo_hit) begin
        mem_enable_reg <= 1'b0;
        tmo_flag_reg   <= 1'b1;
      end
      if (release_exit && tmo_flag_reg) fault_code_reg <= FLT_TIMEOUT;
    end
  end

  assign busy            = (state_reg != IDLE);
  assign done            = (state_reg == DONE);
  assign fault           = (state_reg == FAULT);
  assign fault_code      = fault_code_reg;
  assign rdata           = rdata_reg;
  assign mem_enable      = mem_enable_reg;
  assign mem_read_write  = rw_reg;
  assign mem_data_length = size_reg;
  assign mem_address     = addr_reg;
  assign mem_data_in     = wdata_reg;

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed scoreboard bench for mem_access_controller with a simple RAM
// model (mfc rises 3 cycles after enable, drops 1 cycle after enable falls).
module tb_mem_access_controller;

  localparam int ADDR_W = 9;
  localparam int TMO    = 15;
  // Timing seen from the bench: enable lasts RAM delay (3) + sync (2) + 1.
  localparam int EN_OK    = 6;
  localparam int LAT_OK   = 11;
  localparam int LAT_TMO  = TMO + 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req = 1'b0, req_rw = 1'b0, req_signed = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'd0;
  logic              busy, done, fault, mem_enable, mem_read_write;
  logic [1:0]        fault_code, mem_data_length;
  logic [31:0]       rdata, mem_data_in, mem_data_out;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_mfc;

  always #5 clk = ~clk;

  mem_access_controller #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .fault(fault), .fault_code(fault_code), .rdata(rdata),
    .mem_enable(mem_enable), .mem_read_write(mem_read_write),
    .mem_data_length(mem_data_length), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_mfc(mem_mfc)
  );

  // RAM model
  logic        ram_silent = 1'b0;
  logic [31:0] ram_data = 32'd0;
  int unsigned en_cnt;
  assign mem_data_out = ram_data;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_mfc <= 1'b0;
      en_cnt  <= 0;
    end else if (mem_enable) begin
      en_cnt <= en_cnt + 1;
      if (en_cnt == 2 && !ram_silent) mem_mfc <= 1'b1;
    end else begin
      en_cnt  <= 0;
      mem_mfc <= 1'b0;
    end
  end

  typedef struct {
    logic        is_fault;
    logic [1:0]  code;
    logic [31:0] rdata;
    int          en_cycles;
    int          latency;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_rdata = 32'd0;

  function automatic logic [31:0] model_ext(input logic [31:0] d, input logic [1:0] sz,
                                            input logic sg);
    logic [31:0] r;
    case (sz)
      2'd0: begin r = d & 32'h0000_00FF; if (sg && d[7])  r = r | 32'hFFFF_FF00; end
      2'd1: begin r = d & 32'h0000_FFFF; if (sg && d[15]) r = r | 32'hFFFF_0000; end
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic request(input string name, input logic rw, input logic [1:0] sz,
                         input logic sg, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input bit intrude);
    exp_t e;
    int   cyc, en, hold_bad, pulses;
    bit   seen;
    logic obs_fault;
    logic [1:0] obs_code;
    // prediction pushed to the scoreboard at drive time
    e.rdata = model_rdata;
    if (sz == 2'd3) begin
      e.is_fault = 1'b1; e.code = 2'b11; e.en_cycles = 0; e.latency = 1;
    end else if ((sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00)) begin
      e.is_fault = 1'b1; e.code = 2'b01; e.en_cycles = 0; e.latency = 1;
    end else if (ram_silent) begin
      e.is_fault = 1'b1; e.code = 2'b10; e.en_cycles = TMO; e.latency = LAT_TMO;
    end else begin
      e.is_fault = 1'b0; e.code = 2'b00; e.en_cycles = EN_OK; e.latency = LAT_OK;
      if (rw) e.rdata = model_ext(rd, sz, sg);
    end
    model_rdata = e.rdata;
    sb.push_back(e);

    @(negedge clk);
    ram_data = rd; req_rw = rw; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;

    cyc = 0; en = 0; hold_bad = 0; seen = 0; obs_fault = 1'b0; obs_code = 2'b00;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (intrude && cyc == 2) begin req = 1'b1; req_addr = addr ^ 9'h1F0; end
      if (intrude && cyc == 3) req = 1'b0;
      if (mem_enable) en++;
      if (mem_address !== addr || mem_data_length !== sz ||
          mem_read_write !== rw || mem_data_in !== wd) hold_bad++;
      if (done || fault) begin
        seen = 1; obs_fault = fault; obs_code = fault_code;
      end
    end
    pulses = seen ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (done || fault) pulses++;
    end

    e = sb.pop_front();
    chk({name, " completed"}, 32'(seen), 32'd1);
    chk({name, " fault"}, 32'(obs_fault), 32'(e.is_fault));
    chk({name, " code"}, 32'(obs_code), 32'(e.code));
    chk({name, " rdata"}, rdata, e.rdata);
    chk({name, " enable_cycles"}, 32'(en), 32'(e.en_cycles));
    chk({name, " latency"}, 32'(cyc), 32'(e.latency));
    chk({name, " pulses"}, 32'(pulses), 32'd1);
    chk({name, " held_outputs"}, 32'(hold_bad), 32'd0);
    $display("txn %s: rw=%0b size=%0d addr=0x%03h fault=%0b code=%0d rdata=0x%08h en=%0d lat=%0d",
             name, rw, sz, addr, obs_fault, obs_code, rdata, en, cyc);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset fault", 32'(fault), 32'd0);
    chk("reset mem_enable", 32'(mem_enable), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset fault_code", 32'(fault_code), 32'd0);
    chk("reset mem_address", 32'(mem_address), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    request("rd_byte_signed", 1'b1, 2'd0, 1'b1, 9'h000, 32'd0, 32'h0000_00F0, 1'b0);
    request("wr_half", 1'b0, 2'd1, 1'b0, 9'h002, 32'h0000_0400, 32'hDEAD_BEEF, 1'b0);
    request("rd_word", 1'b1, 2'd2, 1'b0, 9'h008, 32'd0, 32'h0010_0000, 1'b0);
    request("half_misalign", 1'b1, 2'd1, 1'b0, 9'h003, 32'd0, 32'h1234_5678, 1'b0);
    request("word_misalign", 1'b0, 2'd2, 1'b0, 9'h00A, 32'h55AA_55AA, 32'd0, 1'b0);
    request("size_illegal", 1'b1, 2'd3, 1'b0, 9'h010, 32'd0, 32'd0, 1'b0);
    ram_silent = 1'b1;
    request("timeout", 1'b1, 2'd2, 1'b0, 9'h020, 32'd0, 32'hFFFF_FFFF, 1'b0);
    ram_silent = 1'b0;
    request("rd_byte_intrude", 1'b1, 2'd0, 1'b0, 9'h011, 32'd0, 32'h0000_0080, 1'b1);
    request("rd_half_unsigned", 1'b1, 2'd1, 1'b0, 9'h0FE, 32'd0, 32'h0000_9ABC, 1'b0);

    // reset in the middle of WAIT_MFC
    @(negedge clk);
    ram_data = 32'h0000_0001; req_rw = 1'b1; req_size = 2'd2; req_addr = 9'h040; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid enable before reset", 32'(mem_enable), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid reset mem_enable", 32'(mem_enable), 32'd0);
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset done", 32'(done), 32'd0);
    chk("mid reset fault", 32'(fault), 32'd0);
    model_rdata = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    request("after_reset", 1'b1, 2'd1, 1'b1, 9'h004, 32'd0, 32'h0000_8001, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
